simul_axi_ready_gen: RTL

// Simulation-only, multi-channel AXI ready generator for testbenches, one independent valid/ready pair per channel.

---
 rtl/simul_axi_ready_gen.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/simul_axi_ready_gen.sv
// Multi-channel AXI ready generator for testbenches: fixed delay, LFSR-random delay or eager ready with back-off.
// Define SIMUL_AXI_READY_STATS_EN to add per-channel handshake count and max-wait outputs.
module simul_axi_ready_gen #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned DELAY_W = 4,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2*NCH-1:0]         mode,
  input  logic [DELAY_W*NCH-1:0]   delay,
  input  logic [NCH-1:0]           valid,
  output logic [NCH-1:0]           ready
`ifdef SIMUL_AXI_READY_STATS_EN
  ,
  output logic [32*NCH-1:0]        hs_count,
  output logic [DELAY_W*NCH-1:0]   max_wait
`endif
);

  localparam int unsigned REM_W = 17;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [DELAY_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_RAND  = 2'd1,
    MODE_EAGER = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // Mode-change detection is suppressed in the first cycle after reset, when mode_q is not yet valid.
  logic arm_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) arm_q <= 1'b0;
    else          arm_q <= 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [15:0] SEED_X = SEED ^ 16'(i + 1);
    localparam logic [15:0] SEED_I = (SEED_X == 16'h0000) ? 16'h0001 : SEED_X;

    mode_e              mode_raw, mode_eff, mode_q, mode_d;
    logic [DELAY_W-1:0] dly, wait_q, wait_d, eff_q, eff_d, wait_inc, rnd;
    logic [REM_W-1:0]   rem;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               bo_q, bo_d, rdy, hs;

    assign mode_raw = mode_e'(mode[2*i +: 2]);
    assign mode_eff = (mode_raw == MODE_RSVD) ? MODE_FIXED : mode_raw;
    assign dly      = delay[DELAY_W*i +: DELAY_W];
    assign wait_inc = (wait_q == CNT_MAX) ? wait_q : wait_q + DELAY_W'(1);
    assign rem      = REM_W'(lfsr_q) % (REM_W'(dly) + REM_W'(1));
    assign rnd      = DELAY_W'(rem);
    assign hs       = valid[i] & rdy;
    assign ready[i] = reset_n & rdy;

    // Raw ready per mode; eager mode ignores valid and only honours the back-off window.
    always_comb begin
      rdy = 1'b0;
      case (mode_eff)
        MODE_RAND:  rdy = valid[i] && ((wait_q == '0) ? (rnd == '0) : (wait_q >= eff_q));
        MODE_EAGER: rdy = !bo_q || (wait_q >= dly);
        default:    rdy = valid[i] && ((dly == '0) || (wait_q >= dly));
      endcase
    end

    always_comb begin
      wait_d = wait_q;
      eff_d  = eff_q;
      bo_d   = bo_q;
      mode_d = mode_eff;
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      case (mode_eff)
        MODE_RAND: begin
          bo_d = 1'b0;
          if (!valid[i] || hs) begin
            wait_d = '0;
            eff_d  = '0;
          end else begin
            wait_d = wait_inc;
            if (wait_q == '0) eff_d = rnd;
          end
        end
        MODE_EAGER: begin
          eff_d = '0;
          if (hs) begin
            bo_d   = 1'b1;
            wait_d = '0;
          end else if (bo_q && (wait_q < dly)) begin
            wait_d = wait_inc;
          end else begin
            bo_d   = 1'b0;
            wait_d = '0;
          end
        end
        default: begin
          bo_d   = 1'b0;
          eff_d  = '0;
          wait_d = (!valid[i] || hs) ? '0 : wait_inc;
        end
      endcase
      if (arm_q && (mode_eff != mode_q)) begin
        wait_d = '0;
        eff_d  = '0;
        bo_d   = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wait_q <= '0;
        eff_q  <= '0;
        bo_q   <= 1'b0;
        lfsr_q <= SEED_I;
        mode_q <= MODE_FIXED;
      end else begin
        wait_q <= wait_d;
        eff_q  <= eff_d;
        bo_q   <= bo_d;
        lfsr_q <= lfsr_d;
        mode_q <= mode_d;
      end
    end

`ifdef SIMUL_AXI_READY_STATS_EN
    logic [31:0]        hs_cnt_q, hs_cnt_d;
    logic [DELAY_W-1:0] max_q, max_d;

    always_comb begin
      hs_cnt_d = hs_cnt_q;
      max_d    = max_q;
      if (hs) begin
        hs_cnt_d = hs_cnt_q + 32'd1;
        if (wait_q > max_q) max_d = wait_q;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hs_cnt_q <= '0;
        max_q    <= '0;
      end else begin
        hs_cnt_q <= hs_cnt_d;
        max_q    <= max_d;
      end
    end

    assign hs_count[32*i +: 32]           = hs_cnt_q;
    assign max_wait[DELAY_W*i +: DELAY_W] = max_q;
`endif
  end

endmodule
